// File: rtl/nn_vector_loader_pkg.sv
// Shared numeric types for the nn_* blocks plus the vector loader's state encoding.
package nn_vector_loader_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 8;

    typedef logic signed [DATA_W-1:0] nn_data_t;

    typedef enum logic [1:0] {
        StLoad,
        StDrain,
        StCompute,
        StOutput
    } nn_loader_state_e;

    localparam int unsigned NN_LOADER_TIMEOUT = 64;

endpackage

// File: rtl/nn_vector_loader.sv
// Streaming front end for nn_perceptron: packs a word stream into a parallel vector,
// holds it while the perceptron computes, and returns the result on an output stream.
module nn_vector_loader
    import nn_vector_loader_pkg::*;
#(
    parameter int unsigned FEATURES = 11,
    parameter int unsigned TIMEOUT  = NN_LOADER_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  nn_data_t                  s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output nn_data_t [FEATURES-1:0]   vec_o,
    output logic                      vec_v,
    input  nn_data_t                  res_i,
    input  logic                      res_v_i,
    output nn_data_t                  m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_timeout,
    output logic                      len_err
);

    localparam int unsigned IdxW = $clog2(FEATURES);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FEATURES - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    nn_loader_state_e        r_state;
    logic [IdxW-1:0]         r_idx;
    logic [CntW-1:0]         r_cnt;
    nn_data_t [FEATURES-1:0] r_vec;
    logic                    r_vec_v;
    nn_data_t                r_m_data;
    logic                    r_m_valid;
    logic                    r_m_timeout;
    logic                    r_len_err;

    logic                    w_s_ready;
    logic                    w_s_hs;

    // Gated by rst so the source sees no ready while reset is held.
    assign w_s_ready = !rst && (r_state == StLoad || r_state == StDrain);
    assign w_s_hs    = s_valid && w_s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_vec       <= '0;
            r_vec_v     <= 1'b0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_timeout <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            unique case (r_state)
                StLoad: begin
                    if (w_s_hs) begin
                        r_vec[r_idx] <= s_data;
                        if (s_last) begin
                            r_len_err <= (r_idx != LastIdx);
                            r_vec_v   <= 1'b1;
                            r_state   <= StCompute;
                        end else if (r_idx == LastIdx) begin
                            r_len_err <= 1'b1;
                            r_state   <= StDrain;
                        end else begin
                            r_idx <= r_idx + IdxW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_s_hs && s_last) begin
                        r_vec_v <= 1'b1;
                        r_state <= StCompute;
                    end
                end
                StCompute: begin
                    // A result arriving on the timeout cycle takes priority over the abort.
                    if (res_v_i) begin
                        r_m_data    <= res_i;
                        r_m_timeout <= 1'b0;
                        r_m_valid   <= 1'b1;
                        r_vec_v     <= 1'b0;
                        r_state     <= StOutput;
                    end else if (r_cnt == LastCnt) begin
                        r_m_data    <= '0;
                        r_m_timeout <= 1'b1;
                        r_m_valid   <= 1'b1;
                        r_vec_v     <= 1'b0;
                        r_state     <= StOutput;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StOutput: begin
                    if (m_ready) begin
                        r_m_valid   <= 1'b0;
                        r_m_timeout <= 1'b0;
                        r_vec       <= '0;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_state     <= StLoad;
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    assign s_ready   = w_s_ready;
    assign vec_o     = r_vec;
    assign vec_v     = r_vec_v;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_timeout = r_m_timeout;
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_nn_vector_loader.sv
// Directed plus randomized bench for nn_vector_loader against a queue-level reference model.
module tb_nn_vector_loader;
    import nn_vector_loader_pkg::*;

    localparam int unsigned FEATURES = 11;
    localparam int unsigned TIMEOUT  = 64;

    logic                    clk;
    logic                    rst;
    nn_data_t                s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    nn_data_t [FEATURES-1:0] vec_o;
    logic                    vec_v;
    nn_data_t                res_i;
    logic                    res_v_i;
    nn_data_t                m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_timeout;
    logic                    len_err;

    nn_vector_loader #(
        .FEATURES (FEATURES),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .vec_o     (vec_o),
        .vec_v     (vec_v),
        .res_i     (res_i),
        .res_v_i   (res_v_i),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_timeout (m_timeout),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       len_err_total = 0;
    nn_data_t tb_words [16];

    always @(negedge clk) if (len_err === 1'b1) len_err_total++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the first FEATURES words survive, the rest of the vector is zero.
    function automatic logic [FEATURES*16-1:0] model_vec(input int n);
        nn_data_t [FEATURES-1:0] v;
        v = '0;
        for (int i = 0; i < n && i < FEATURES; i++) v[i] = tb_words[i];
        return v;
    endfunction

    task automatic send_words(input int n, input bit gaps);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    res_v_i = 1'($urandom_range(0, 1));
                    res_i   = nn_data_t'($urandom);
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = tb_words[i];
            s_last  = (i == n - 1);
            res_v_i = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            res_i   = nn_data_t'($urandom);
            guard   = 0;
            while (s_ready !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("s_ready_word%0d", i), 256'(s_ready), 256'(1'b1));
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        res_v_i = 1'b0;
    endtask

    // delay 0 = perceptron never answers; otherwise res_v_i in the delay-th vec_v cycle.
    task automatic run_vector(input string tag, input int n, input int delay, input nn_data_t res,
                              input int hold, input bit gaps);
        logic [FEATURES*16-1:0] exp_vec;
        int       err_before;
        int       cyc;
        int       exp_cyc;
        bit       answered;
        nn_data_t exp_data;
        nn_data_t held;

        exp_vec    = model_vec(n);
        err_before = len_err_total;
        answered   = (delay >= 1 && delay <= TIMEOUT);
        exp_cyc    = answered ? delay : TIMEOUT;
        exp_data   = answered ? res : '0;

        send_words(n, gaps);
        check({tag, "_vec_v_latency"}, 256'(vec_v), 256'(1'b1));
        check({tag, "_vec_o"}, 256'(vec_o), 256'(exp_vec));
        check({tag, "_s_ready_compute"}, 256'(s_ready), 256'(1'b0));

        cyc = 0;
        while (vec_v === 1'b1 && cyc < 200) begin
            cyc++;
            if (delay != 0 && cyc == delay) begin
                res_v_i = 1'b1;
                res_i   = res;
            end
            @(negedge clk);
            res_v_i = 1'b0;
            res_i   = nn_data_t'($urandom);
        end
        check({tag, "_vec_v_cycles"}, 256'(cyc), 256'(exp_cyc));
        check({tag, "_m_valid"}, 256'(m_valid), 256'(1'b1));
        check({tag, "_m_timeout"}, 256'(m_timeout), 256'(!answered));
        check({tag, "_m_data"}, 256'(m_data), 256'(exp_data));
        check({tag, "_vec_o_held"}, 256'(vec_o), 256'(exp_vec));

        held = m_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            res_v_i = 1'($urandom_range(0, 1));
            if (h == hold - 1) begin
                check({tag, "_bp_m_valid"}, 256'(m_valid), 256'(1'b1));
                check({tag, "_bp_m_data"}, 256'(m_data), 256'(held));
            end
            if (s_ready !== 1'b0) check({tag, "_bp_s_ready"}, 256'(s_ready), 256'(1'b0));
        end
        res_v_i = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_post_m_valid"}, 256'(m_valid), 256'(1'b0));
        check({tag, "_post_s_ready"}, 256'(s_ready), 256'(1'b1));
        check({tag, "_post_vec_o"}, 256'(vec_o), 256'(0));
        check({tag, "_len_err"}, 256'(len_err_total - err_before), 256'(n != FEATURES));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        res_i   = '0;
        res_v_i = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 256'(s_ready), 256'(0));
        check("rst_vec_o", 256'(vec_o), 256'(0));
        check("rst_vec_v", 256'(vec_v), 256'(0));
        check("rst_m_data", 256'(m_data), 256'(0));
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_timeout", 256'(m_timeout), 256'(0));
        check("rst_len_err", 256'(len_err), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 256'(s_ready), 256'(1));

        for (int i = 0; i < FEATURES; i++) tb_words[i] = nn_data_t'((i + 1) * 16'h0100);
        run_vector("nominal", FEATURES, 3, 16'h0280, 0, 1'b0);

        for (int i = 0; i < 4; i++) tb_words[i] = nn_data_t'((i + 1) * 16'h0010);
        run_vector("short", 4, 1 + int'($urandom_range(0, 9)), nn_data_t'($urandom), 1, 1'b0);

        for (int i = 0; i < 13; i++) tb_words[i] = nn_data_t'($urandom);
        run_vector("long", 13, 5, nn_data_t'($urandom), 0, 1'b0);

        for (int i = 0; i < FEATURES; i++) tb_words[i] = nn_data_t'($urandom);
        run_vector("timeout", FEATURES, 0, nn_data_t'($urandom), 20, 1'b0);

        for (int i = 0; i < FEATURES; i++) tb_words[i] = nn_data_t'($urandom);
        run_vector("tie", FEATURES, TIMEOUT, 16'h7ABC, 2, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int n;
            int d;
            n = int'($urandom_range(1, 14));
            d = (k % 4 == 3) ? 0 : int'($urandom_range(1, 70));
            for (int i = 0; i < n; i++) tb_words[i] = nn_data_t'($urandom);
            run_vector($sformatf("rand%0d", k), n, d, nn_data_t'($urandom),
                       int'($urandom_range(0, 5)), 1'b1);
        end

        // Abort a partial vector with reset and confirm the next one starts clean.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = nn_data_t'(16'h5A00 + i);
            s_last  = 1'b0;
        end
        @(negedge clk);
        check("midload_vec_o_nonzero", 256'(vec_o[0]), 256'(nn_data_t'(16'h5A00)));
        #2;
        rst = 1'b1;
        #1;
        check("async_vec_o", 256'(vec_o), 256'(0));
        check("async_s_ready", 256'(s_ready), 256'(0));
        check("async_vec_v", 256'(vec_v), 256'(0));
        check("async_m_valid", 256'(m_valid), 256'(0));
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FEATURES; i++) tb_words[i] = nn_data_t'(16'h1000 + i);
        run_vector("after_rst", FEATURES, 2, 16'h0042, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
